// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared constants and helpers for the pipelined add/subtract unit.
//   - DEFAULT_WIDTH / DEFAULT_CHUNK : default operand width and bits per stage
//   - calc_stages()                 : number of pipeline stages (= latency)
//   - chunking_ok()                 : legality of a WIDTH/CHUNK pair, used to
//                                     stop elaboration on a bad combination
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // One register stage per CHUNK-bit slice of the carry chain.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The slices must tile the operand exactly; a partial top slice would
    // leave the MSB carry (and therefore co/ovf) in the wrong place.
    function automatic bit chunking_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage : adder_pkg

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
//   Combinational CHUNK-bit ripple-carry adder: one slice of the pipelined
//   carry chain.
//   Ports:
//     a, b  in  CHUNK  addends (b is already inverted for subtraction)
//     ci    in  1      carry into bit 0 of the slice
//     s     out CHUNK  slice sum
//     co    out 1      carry out of the slice MSB
//     cim   out 1      carry into the slice MSB (signed overflow needs it)
// -----------------------------------------------------------------------------
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cim
);

    // c[i] is the carry into bit i; c[CHUNK] is the carry out of the slice.
    logic [CHUNK:0] c;

    always_comb begin
        // NOTE: every bit of s and c is assigned on every pass through this
        // block (defaults first, then the ripple), so no latch can be inferred.
        s = '0;
        c = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co  = c[CHUNK];
    assign cim = c[CHUNK-1];

endmodule : chunk_adder

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit add/subtract unit whose carry chain is cut into CHUNK-bit
//   slices, one register stage per slice. Issue rate is one operation per
//   cycle; latency is WIDTH/CHUNK cycles. Valid/ready on both sides, with a
//   global stall when the consumer holds off a presented result.
//   Ports:
//     clk        in  1      rising-edge clock
//     rst_n      in  1      asynchronous active-low reset
//     in_valid   in  1      operands present
//     in_ready   out 1      operands accepted this cycle (= not stalled)
//     a, b       in  WIDTH  operands (unsigned or two's complement)
//     ci         in  1      carry-in (add) / borrow-in (sub)
//     sub        in  1      0: a+b+ci, 1: a-b-ci
//     out_valid  out 1      result present
//     out_ready  in  1      consumer accepts the result
//     sum        out WIDTH  result modulo 2^WIDTH
//     co         out 1      carry out; in subtract mode 1 means "no borrow"
//     ovf        out 1      signed overflow
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunking
        $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    // Subtraction is a + ~b + 1; a borrow-in removes that +1, hence ci ^ sub.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             stall;
    logic             advance;

    assign b_eff = b ^ {WIDTH{sub}};
    assign c_eff = ci ^ sub;

    // A result waiting on the consumer freezes the whole pipe, bubbles
    // included, so the presented result cannot change underneath it.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    // -------------------------------------------------------------------------
    // Skewed pipeline. Stage k adds slice k. Its registers carry:
    //   sum_q      : sum bits [0 +: (k+1)*CHUNK], complete so far
    //   carry_q    : carry out of slice k
    //   a/b_pend_q : operand bits not yet added (absent in the last stage)
    //   valid_q    : the stage holds a real operation rather than a bubble
    // Each stage only stores what is still live, so register widths change
    // from stage to stage.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE_W = (k + 1) * CHUNK;
        localparam int PEND_W = WIDTH - DONE_W;

        logic [CHUNK-1:0]  a_chunk;
        logic [CHUNK-1:0]  b_chunk;
        logic [CHUNK-1:0]  s_chunk;
        logic              c_in;
        logic              c_out;
        logic              c_msb;

        logic              valid_d;
        logic              carry_d;
        logic [DONE_W-1:0] sum_d;

        logic              valid_q;
        logic              carry_q;
        logic [DONE_W-1:0] sum_q;

        if (k == 0) begin : g_src
            assign a_chunk = a[CHUNK-1:0];
            assign b_chunk = b_eff[CHUNK-1:0];
            assign c_in    = c_eff;
            assign valid_d = in_valid;
            assign sum_d   = s_chunk;
        end else begin : g_src
            assign a_chunk = g_stage[k-1].g_pend.a_pend_q[CHUNK-1:0];
            assign b_chunk = g_stage[k-1].g_pend.b_pend_q[CHUNK-1:0];
            assign c_in    = g_stage[k-1].carry_q;
            assign valid_d = g_stage[k-1].valid_q;
            // Lower sum slices ride along with their operation.
            assign sum_d   = {s_chunk, g_stage[k-1].sum_q};
        end

        chunk_adder #(
            .CHUNK (CHUNK)
        ) u_chunk_adder (
            .a   (a_chunk),
            .b   (b_chunk),
            .ci  (c_in),
            .s   (s_chunk),
            .co  (c_out),
            .cim (c_msb)
        );

        assign carry_d = c_out;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: the data registers are reset along with the valid bits
                // so that sum/co read 0 straight out of reset.
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                // NOTE: state updates use non-blocking assignments, so every
                // stage samples its neighbour's pre-edge value and the skew
                // between stages is preserved.
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // Operand bits still waiting for a later slice, shifted down so the
        // next stage always finds its slice at bit 0.
        if (PEND_W > 0) begin : g_pend
            logic [PEND_W-1:0] a_pend_d;
            logic [PEND_W-1:0] b_pend_d;
            logic [PEND_W-1:0] a_pend_q;
            logic [PEND_W-1:0] b_pend_q;

            if (k == 0) begin : g_pend_src
                assign a_pend_d = a[WIDTH-1:CHUNK];
                assign b_pend_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_pend_src
                assign a_pend_d = g_stage[k-1].g_pend.a_pend_q[PEND_W+CHUNK-1:CHUNK];
                assign b_pend_d = g_stage[k-1].g_pend.b_pend_q[PEND_W+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_pend_q <= '0;
                    b_pend_q <= '0;
                end else if (advance) begin
                    a_pend_q <= a_pend_d;
                    b_pend_q <= b_pend_d;
                end
            end
        end

        // Signed overflow only depends on the carries around the true MSB,
        // which lives in the top slice.
        if (k == STAGES - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = c_msb ^ c_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_mid
            logic unused_c_msb;
            assign unused_c_msb = c_msb;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign co        = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule : pipelined_adder

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Four instances share one operand bus: the default 16/4 unit plus the
//   8/8, 32/4 and 12/3 variants. Only the 16/4 unit sees backpressure; the
//   others always have out_ready high. Expected results queue per instance
//   and are compared, in order, as each result leaves the unit.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } vec_t;

    localparam int NDUT = 4;
    localparam int NVEC = 14;

    int dut_w   [NDUT] = '{16, 8, 32, 12};
    int dut_lat [NDUT] = '{4, 1, 8, 4};

    logic        clk;
    logic        rst_n;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        ci_drv;
    logic        sub_drv;
    logic [3:0]  in_valid_v;
    logic        m_out_ready;

    wire  [3:0]  in_ready_v;
    wire  [3:0]  out_valid_v;
    wire  [3:0]  out_ready_v;
    wire  [3:0]  co_v;
    wire  [3:0]  ovf_v;
    wire  [15:0] sum16;
    wire  [7:0]  sum8;
    wire  [31:0] sum32;
    wire  [11:0] sum12;
    wire  [31:0] o_sum [NDUT];

    assign out_ready_v = {3'b111, m_out_ready};
    assign o_sum[0]    = {16'b0, sum16};
    assign o_sum[1]    = {24'b0, sum8};
    assign o_sum[2]    = sum32;
    assign o_sum[3]    = {20'b0, sum12};

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q [NDUT][$];
    int   rx [NDUT] = '{0, 0, 0, 0};

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .ci(ci_drv), .sub(sub_drv),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum16), .co(co_v[0]), .ovf(ovf_v[0])
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_dut_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .ci(ci_drv), .sub(sub_drv),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum8), .co(co_v[1]), .ovf(ovf_v[1])
    );

    pipelined_adder #(.WIDTH(32), .CHUNK(4)) u_dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_drv), .b(b_drv), .ci(ci_drv), .sub(sub_drv),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum32), .co(co_v[2]), .ovf(ovf_v[2])
    );

    pipelined_adder #(.WIDTH(12), .CHUNK(3)) u_dut_w12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_drv[11:0]), .b(b_drv[11:0]), .ci(ci_drv), .sub(sub_drv),
        .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
        .sum(sum12), .co(co_v[3]), .ovf(ovf_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic civ, input logic subv);
        longint mask, ua, ub, c, full, sa, sb, res, lim;
        exp_t   e;
        mask  = (longint'(1) << w) - 1;
        ua    = longint'({32'b0, av}) & mask;
        ub    = longint'({32'b0, bv}) & mask;
        c     = civ ? 1 : 0;
        full  = subv ? (ua - ub - c) : (ua + ub + c);
        e.sum = 32'(full & mask);
        e.co  = subv ? (full >= 0) : (((full >> w) & 1) != 0);
        sa    = (((ua >> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
        sb    = (((ub >> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
        res   = subv ? (sa - sb - c) : (sa + sb + c);
        lim   = longint'(1) << (w - 1);
        e.ovf = (res >= lim) || (res < -lim);
        return e;
    endfunction

    // Present one operation to the instances in mask and hold it until all
    // of them accept it; the expected result is queued at acceptance.
    task automatic issue(input logic [3:0] mask, input logic [31:0] av, input logic [31:0] bv,
                         input logic civ, input logic subv, input bit fixed, input exp_t fexp);
        bit ok;
        ok         = 1'b0;
        a_drv      = av;
        b_drv      = bv;
        ci_drv     = civ;
        sub_drv    = subv;
        in_valid_v = mask;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if ((in_ready_v & mask) == mask) begin
                ok = 1'b1;
                for (int d = 0; d < NDUT; d++)
                    if (mask[d])
                        exp_q[d].push_back(fixed ? fexp : model(dut_w[d], av, bv, civ, subv));
            end
            @(posedge clk);
            #1;
        end
        in_valid_v = '0;
        if (!ok) check("issue_timeout", 64'(ok), 64'd1);
    endtask

    // Output monitor: in-order scoreboard, hold stability and in_ready under stall.
    logic [3:0]  held;
    logic [33:0] held_val [NDUT];
    logic [33:0] cur;
    exp_t        e_pop;

    initial begin
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = '0;
            end else begin
                for (int d = 0; d < NDUT; d++) begin
                    cur = {o_sum[d], co_v[d], ovf_v[d]};
                    if (held[d]) begin
                        check($sformatf("hold_valid[%0d]", d), 64'(out_valid_v[d]), 64'd1);
                        check($sformatf("hold_data[%0d]", d), 64'(cur), 64'(held_val[d]));
                    end
                    if (out_valid_v[d] && !out_ready_v[d])
                        check($sformatf("stall_in_ready[%0d]", d), 64'(in_ready_v[d]), 64'd0);
                    if (out_valid_v[d] && out_ready_v[d]) begin
                        if (exp_q[d].size() == 0) begin
                            check($sformatf("spurious_result[%0d]", d), 64'(exp_q[d].size()), 64'd1);
                        end else begin
                            e_pop = exp_q[d].pop_front();
                            check($sformatf("sum[%0d]#%0d", d, rx[d]), 64'(o_sum[d]), 64'(e_pop.sum));
                            check($sformatf("co[%0d]#%0d", d, rx[d]), 64'(co_v[d]), 64'(e_pop.co));
                            check($sformatf("ovf[%0d]#%0d", d, rx[d]), 64'(ovf_v[d]), 64'(e_pop.ovf));
                            rx[d]++;
                        end
                    end
                    held[d]     = out_valid_v[d] && !out_ready_v[d];
                    held_val[d] = cur;
                end
            end
        end
    end

    vec_t   vecs [NVEC];
    int     lat  [NDUT];
    int     rx0;
    longint t0;

    initial begin
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[10] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[12] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[13] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst_n       = 1'b0;
        in_valid_v  = '0;
        a_drv       = '0;
        b_drv       = '0;
        ci_drv      = 1'b0;
        sub_drv     = 1'b0;
        m_out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("reset_sum", 64'(sum16), 64'd0);
        check("reset_co", 64'(co_v[0]), 64'd0);
        check("reset_ovf", 64'(ovf_v[0]), 64'd0);
        check("reset_in_ready", 64'(in_ready_v[0]), 64'd1);
        @(posedge clk);
        #1;

        // Latency of each parameter set, measured from a single operation.
        issue(4'b1111, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, '0);
        for (int d = 0; d < NDUT; d++) lat[d] = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++)
                if (lat[d] == 0 && out_valid_v[d]) lat[d] = k;
        end
        for (int d = 0; d < NDUT; d++)
            check($sformatf("latency[%0d]", d), 64'(lat[d]), 64'(dut_lat[d]));
        @(posedge clk);
        #1;

        // Directed vectors, back to back, hand-computed results.
        for (int i = 0; i < NVEC; i++)
            issue(4'b0001, {16'b0, vecs[i].a}, {16'b0, vecs[i].b}, vecs[i].ci, vecs[i].sub,
                  1'b1, '{{16'b0, vecs[i].sum}, vecs[i].co, vecs[i].ovf});
        repeat (6) @(negedge clk);
        #1;
        check("directed_drained", 64'(exp_q[0].size()), 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: 6 operations with out_ready low for 5 cycles mid-stream.
        rx0 = rx[0];
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(4'b0001, 32'($urandom), 32'($urandom), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'b0, '0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                m_out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_out_ready = 1'b1;
            end
        join
        repeat (12) @(negedge clk);
        #1;
        check("bp_drained", 64'(exp_q[0].size()), 64'd0);
        check("bp_result_count", 64'(rx[0] - rx0), 64'd6);
        @(posedge clk);
        #1;

        // Streaming: 100 back-to-back operations into every parameter set.
        t0 = longint'($time);
        for (int i = 0; i < 100; i++)
            issue(4'b1111, 32'($urandom), 32'($urandom), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'b0, '0);
        check("stream_issue_cycles", 64'((longint'($time) - t0) / 10), 64'd100);
        repeat (8) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("stream_drained[%0d]", d), 64'(exp_q[d].size()), 64'd0);
        @(posedge clk);
        #1;

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++)
            issue(4'b0001, 32'(16'h1111 * (i + 1)), 32'd3, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        check("inflight_valid", 64'(out_valid_v[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("midreset_sum", 64'(sum16), 64'd0);
        check("midreset_in_ready", 64'(in_ready_v[0]), 64'd1);
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("post_reset_idle", 64'(out_valid_v[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pipelined_adder
